bus_seq_key: RTL and testbench

- Bus-snooping, access-sequenced key/response engine sitting on the buffered CPU address bus (BA lines) behind the board select.
- Watches qualified accesses inside a decoded address window and treats the address nibble as a command.
- A programmable command sequence unlocks the engine. Once unlocked, each qualified read returns one bit of a parametrised LFSR stream on the serial data-read line.
- Generalises the fixed 6-bit sequencer: width, decode window, key length/value, relock command, timeout and write-acceptance are all configurable.

---
 rtl/bus_seq_key_if.sv | 31 +++
 rtl/bus_seq_key.sv | 172 +++++++++++++++++
 tb/tb_bus_seq_key.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_seq_key_if.sv
// ---------------------------------------------------------------------------
// bus_seq_key_if
// Bus-side signal bundle for the access-sequenced key engine.
//   bus_addr  : buffered CPU address (BA lines)
//   bus_rw    : 1 = read, 0 = write
//   bus_sel_n : active-low board select
//   bus_strb  : one-cycle access-qualified pulse, synchronous to clk
//   sd_rd     : serial response bit (engine -> pad)
//   sd_oe     : drive enable for the sd_rd pad
// Modports: master = CPU/bus side, slave = key engine.
// ---------------------------------------------------------------------------
interface bus_seq_key_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rw;
    logic              bus_sel_n;
    logic              bus_strb;
    logic              sd_rd;
    logic              sd_oe;

    modport master (
        output bus_addr, bus_rw, bus_sel_n, bus_strb,
        input  sd_rd, sd_oe
    );

    modport slave (
        input  bus_addr, bus_rw, bus_sel_n, bus_strb,
        output sd_rd, sd_oe
    );
endinterface

// File: rtl/bus_seq_key.sv
// ---------------------------------------------------------------------------
// bus_seq_key
// Snoops qualified accesses in a decoded address window and treats the
// address nibble as a command. A programmable command sequence unlocks the
// engine; once unlocked, each qualified read returns one bit of an LFSR
// stream on sd_rd, one clock after the strobe.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : bus_seq_key_if.slave (address/rw/select/strobe in, sd_rd/sd_oe out)
//   unlocked : engine is in the UNLOCKED state
//   seq_pos  : current key match index
//   lfsr_q   : LFSR state (debug)
// ---------------------------------------------------------------------------
module bus_seq_key #(
    parameter int                          ADDR_W     = 14,
    parameter logic [ADDR_W-1:0]           DEC_MASK   = 14'h3000,
    parameter logic [ADDR_W-1:0]           DEC_MATCH  = 14'h1000,
    parameter int                          CMD_LSB    = 4,
    parameter int                          CMD_W      = 4,
    parameter int                          STATE_W    = 6,
    parameter logic [STATE_W-1:0]          LFSR_TAPS  = 6'b110000,
    parameter logic [STATE_W-1:0]          LFSR_SEED  = 6'h2D,
    parameter int                          SEQ_LEN    = 4,
    parameter logic [SEQ_LEN*CMD_W-1:0]    SEQ_KEY    = 16'h5A3C,
    parameter logic [CMD_W-1:0]            RELOCK_CMD = 4'hF,
    parameter int                          TIMEOUT    = 255,
    parameter bit                          ACCEPT_WR  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_seq_key_if.slave       bus,
    output logic               unlocked,
    output logic [2:0]         seq_pos,
    output logic [STATE_W-1:0] lfsr_q
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_MATCHING = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         pos_reg, pos_next;
    logic [STATE_W-1:0] lfsr_reg, lfsr_next;
    logic [TO_W-1:0]    idle_reg, idle_next;
    logic               sd_rd_reg, sd_rd_next;
    logic               sd_oe_reg, sd_oe_next;

    // Key table padded to 8 entries so a 3-bit seq_pos always indexes it.
    logic [CMD_W-1:0] key_arr [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_key
            if (gi < SEQ_LEN) begin : g_used
                assign key_arr[gi] = SEQ_KEY[gi*CMD_W +: CMD_W];
            end else begin : g_pad
                assign key_arr[gi] = '0;
            end
        end
    endgenerate

    logic [CMD_W-1:0]   cmd;
    logic               hit, rd_hit;
    logic               last_idx;
    logic [TO_W-1:0]    idle_inc;
    logic [STATE_W-1:0] lfsr_step;

    assign cmd      = bus.bus_addr[CMD_LSB +: CMD_W];
    assign hit      = bus.bus_strb & ~bus.bus_sel_n
                    & ((bus.bus_addr & DEC_MASK) == DEC_MATCH)
                    & (bus.bus_rw | ACCEPT_WR);
    assign rd_hit   = hit & bus.bus_rw;
    assign last_idx = (pos_reg == 3'(SEQ_LEN - 1));
    assign idle_inc = idle_reg + 1'b1;
    // An all-zero LFSR would lock up; recover by reloading the seed.
    assign lfsr_step = (lfsr_reg == '0) ? LFSR_SEED
                     : {lfsr_reg[STATE_W-2:0], ^(lfsr_reg & LFSR_TAPS)};

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        lfsr_next  = lfsr_reg;
        idle_next  = '0;
        sd_oe_next = rd_hit;
        sd_rd_next = 1'b0;
        case (state_reg)
            ST_LOCKED: begin
                if (hit && cmd == key_arr[0]) begin
                    if (SEQ_LEN == 1) begin
                        state_next = ST_UNLOCKED;
                        pos_next   = 3'd0;
                        lfsr_next  = LFSR_SEED;
                    end else begin
                        state_next = ST_MATCHING;
                        pos_next   = 3'd1;
                    end
                end
            end
            ST_MATCHING: begin
                if (hit) begin
                    if (cmd == key_arr[pos_reg]) begin
                        if (last_idx) begin
                            state_next = ST_UNLOCKED;
                            pos_next   = 3'd0;
                            lfsr_next  = LFSR_SEED;
                        end else begin
                            pos_next = pos_reg + 3'd1;
                        end
                    end else if (cmd == key_arr[0]) begin
                        // A wrong command that is itself the first key entry
                        // restarts the sequence instead of aborting it.
                        pos_next = 3'd1;
                    end else begin
                        state_next = ST_LOCKED;
                        pos_next   = 3'd0;
                    end
                end else begin
                    idle_next = idle_inc;
                    if (TIMEOUT != 0 && idle_inc == TO_W'(TIMEOUT)) begin
                        state_next = ST_LOCKED;
                        pos_next   = 3'd0;
                        idle_next  = '0;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (hit) begin
                    if (cmd == RELOCK_CMD) begin
                        state_next = ST_LOCKED;
                        pos_next   = 3'd0;
                    end else begin
                        // Response bit is the MSB before the advance.
                        sd_rd_next = rd_hit & lfsr_reg[STATE_W-1];
                        lfsr_next  = lfsr_step;
                    end
                end
            end
            default: begin
                state_next = ST_LOCKED;
                pos_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LOCKED;
            pos_reg   <= 3'd0;
            lfsr_reg  <= LFSR_SEED;
            idle_reg  <= '0;
            sd_rd_reg <= 1'b0;
            sd_oe_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            lfsr_reg  <= lfsr_next;
            idle_reg  <= idle_next;
            sd_rd_reg <= sd_rd_next;
            sd_oe_reg <= sd_oe_next;
        end
    end

    assign bus.sd_rd = sd_rd_reg;
    assign bus.sd_oe = sd_oe_reg;
    assign unlocked  = (state_reg == ST_UNLOCKED);
    assign seq_pos   = pos_reg;
    assign lfsr_q    = lfsr_reg;

endmodule

// File: tb/tb_bus_seq_key.sv
// ---------------------------------------------------------------------------
// tb_bus_seq_key
// Two engines share one bus stimulus: dut0 ignores writes, dut1 accepts them.
// A behavioural model (key position, idle count, LFSR value as integers)
// predicts every output each cycle; literal checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_bus_seq_key;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_seq_key_if #(.ADDR_W(14)) bif0 ();
    bus_seq_key_if #(.ADDR_W(14)) bif1 ();

    logic       unl0, unl1;
    logic [2:0] pos0, pos1;
    logic [5:0] lq0, lq1;

    bus_seq_key #(.ACCEPT_WR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0.slave),
        .unlocked(unl0), .seq_pos(pos0), .lfsr_q(lq0)
    );
    bus_seq_key #(.ACCEPT_WR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bif1.slave),
        .unlocked(unl1), .seq_pos(pos1), .lfsr_q(lq1)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state, one slot per DUT.
    bit m_unl  [2];
    int m_pos  [2];
    int m_idle [2];
    int m_lfsr [2];
    bit e_oe   [2];
    bit e_rd   [2];

    function automatic int key_at(input int i);
        int k;
        k = 'h5A3C;
        return (k >> (4 * i)) & 'hF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_unl[d] = 1'b0; m_pos[d] = 0; m_idle[d] = 0;
            m_lfsr[d] = 'h2D; e_oe[d] = 1'b0; e_rd[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        int  addr, cmd, fb;
        bit  rw, hit;
        addr = int'(bif0.bus_addr);
        rw   = bif0.bus_rw;
        cmd  = (addr >> 4) & 'hF;
        hit  = bif0.bus_strb && !bif0.bus_sel_n && ((addr & 'h3000) == 'h1000)
               && (rw || (d == 1));
        e_oe[d] = hit && rw;
        e_rd[d] = 1'b0;
        if (m_unl[d]) begin
            if (hit) begin
                if (cmd == 'hF) begin
                    m_unl[d] = 1'b0;
                    m_pos[d] = 0;
                end else begin
                    e_rd[d] = rw && (((m_lfsr[d] >> 5) & 1) == 1);
                    if (m_lfsr[d] == 0) m_lfsr[d] = 'h2D;
                    else begin
                        fb = ((m_lfsr[d] >> 5) ^ (m_lfsr[d] >> 4)) & 1;
                        m_lfsr[d] = ((m_lfsr[d] << 1) & 'h3F) | fb;
                    end
                end
            end
        end else if (m_pos[d] == 0) begin
            if (hit && cmd == key_at(0)) begin
                m_pos[d] = 1; m_idle[d] = 0;
            end
        end else begin
            if (hit) begin
                m_idle[d] = 0;
                if (cmd == key_at(m_pos[d])) begin
                    if (m_pos[d] == 3) begin
                        m_unl[d] = 1'b1; m_pos[d] = 0; m_lfsr[d] = 'h2D;
                    end else m_pos[d] = m_pos[d] + 1;
                end else if (cmd == key_at(0)) m_pos[d] = 1;
                else m_pos[d] = 0;
            end else begin
                m_idle[d] = m_idle[d] + 1;
                if (m_idle[d] == 255) begin
                    m_pos[d] = 0; m_idle[d] = 0;
                end
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("unlocked%0d", d), int'(d == 0 ? unl0 : unl1), int'(m_unl[d]));
            check($sformatf("seq_pos%0d", d), int'(d == 0 ? pos0 : pos1), m_pos[d]);
            check($sformatf("lfsr_q%0d", d), int'(d == 0 ? lq0 : lq1), m_lfsr[d]);
            check($sformatf("sd_oe%0d", d), int'(d == 0 ? bif0.sd_oe : bif1.sd_oe), int'(e_oe[d]));
            if (e_oe[d])
                check($sformatf("sd_rd%0d", d), int'(d == 0 ? bif0.sd_rd : bif1.sd_rd), int'(e_rd[d]));
        end
    endtask

    task automatic set_bus(input logic [13:0] addr, input logic rw,
                           input logic sel_n, input logic strb);
        bif0.bus_addr = addr; bif0.bus_rw = rw; bif0.bus_sel_n = sel_n; bif0.bus_strb = strb;
        bif1.bus_addr = addr; bif1.bus_rw = rw; bif1.bus_sel_n = sel_n; bif1.bus_strb = strb;
    endtask

    task automatic access(input logic [13:0] addr, input logic rw, input logic sel_n);
        set_bus(addr, rw, sel_n, 1'b1);
        tick();
        set_bus(14'h0000, 1'b1, 1'b1, 1'b0);
        $display("access addr=%h rw=%0d sel_n=%0d -> unlocked=%0d seq_pos=%0d lfsr=%h sd_oe=%0d sd_rd=%0d",
                 addr, rw, sel_n, unl0, pos0, lq0, bif0.sd_oe, bif0.sd_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic unlock_rd();
        access(14'h10C0, 1'b1, 1'b0);
        access(14'h1030, 1'b1, 1'b0);
        access(14'h10A0, 1'b1, 1'b0);
        access(14'h1050, 1'b1, 1'b0);
    endtask

    initial begin
        logic [13:0] ra;
        int          sel;
        set_bus(14'h0000, 1'b1, 1'b1, 1'b0);
        model_reset();
        #12;
        check("reset_unlocked", int'(unl0), 0);
        check("reset_seq_pos", int'(pos0), 0);
        check("reset_lfsr", int'(lq0), 'h2D);
        check("reset_sd_oe", int'(bif0.sd_oe), 0);
        rst_n = 1'b1;

        // Unlock, then stream three bits.
        unlock_rd();
        check("unlock_flag", int'(unl0), 1);
        check("unlock_sd_rd", int'(bif0.sd_rd), 0);
        access(14'h1000, 1'b1, 1'b0);
        check("stream0_rd", int'(bif0.sd_rd), 1);
        check("stream0_oe", int'(bif0.sd_oe), 1);
        check("stream0_lfsr", int'(lq0), 'h1B);
        access(14'h1000, 1'b1, 1'b0);
        check("stream1_rd", int'(bif0.sd_rd), 0);
        check("stream1_lfsr", int'(lq0), 'h37);
        access(14'h1000, 1'b1, 1'b0);
        check("stream2_rd", int'(bif0.sd_rd), 1);
        check("stream2_lfsr", int'(lq0), 'h2E);
        tick();
        check("oe_single_cycle", int'(bif0.sd_oe), 0);

        // Mid-stream async reset pulse between edges.
        access(14'h1000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_unlocked", int'(unl0), 0);
        check("arst_lfsr", int'(lq0), 'h2D);
        check("arst_sd_oe", int'(bif0.sd_oe), 0);
        check("arst_sd_rd", int'(bif0.sd_rd), 0);
        model_reset();
        #2 rst_n = 1'b1;
        access(14'h1030, 1'b1, 1'b0);
        check("post_arst_locked", int'(unl0), 0);

        // Abort on a wrong command, then restart on a repeated first command.
        access(14'h10C0, 1'b1, 1'b0);
        access(14'h1030, 1'b1, 1'b0);
        access(14'h1070, 1'b1, 1'b0);
        check("abort_pos", int'(pos0), 0);
        access(14'h10C0, 1'b1, 1'b0);
        access(14'h10C0, 1'b1, 1'b0);
        check("restart_pos", int'(pos0), 1);
        access(14'h1030, 1'b1, 1'b0);
        access(14'h10A0, 1'b1, 1'b0);
        access(14'h1050, 1'b1, 1'b0);
        check("restart_unlock", int'(unl0), 1);
        access(14'h10F0, 1'b1, 1'b0);

        // Timeout: 254 idle cycles keep MATCHING, the 255th aborts.
        access(14'h10C0, 1'b1, 1'b0);
        access(14'h1030, 1'b1, 1'b0);
        idle(254);
        check("to_254_pos", int'(pos0), 2);
        tick();
        check("to_255_pos", int'(pos0), 0);
        check("to_255_unl", int'(unl0), 0);
        access(14'h10C0, 1'b1, 1'b0);
        access(14'h1030, 1'b1, 1'b0);
        idle(253);
        access(14'h10A0, 1'b1, 1'b0);
        check("to_hit254_pos", int'(pos0), 3);
        access(14'h1050, 1'b1, 1'b0);
        check("to_hit254_unl", int'(unl0), 1);

        // Relock returns a zero bit with sd_oe asserted.
        access(14'h10F0, 1'b1, 1'b0);
        check("relock_unl", int'(unl0), 0);
        check("relock_oe", int'(bif0.sd_oe), 1);
        check("relock_rd", int'(bif0.sd_rd), 0);

        // Deselected or out-of-window strobes are ignored.
        access(14'h10C0, 1'b1, 1'b1);
        access(14'h30C0, 1'b1, 1'b0);
        check("ignored_pos", int'(pos0), 0);

        // Write-only key: only the write-accepting engine unlocks.
        access(14'h10C0, 1'b0, 1'b0);
        access(14'h1030, 1'b0, 1'b0);
        access(14'h10A0, 1'b0, 1'b0);
        access(14'h1050, 1'b0, 1'b0);
        check("wr_dut0_locked", int'(unl0), 0);
        check("wr_dut1_unlocked", int'(unl1), 1);
        access(14'h1000, 1'b0, 1'b0);
        check("wr_dut1_no_oe", int'(bif1.sd_oe), 0);
        check("wr_dut1_lfsr", int'(lq1), 'h1B);

        // Randomized traffic biased towards in-window key commands.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                case ($urandom_range(0, 5))
                    0: ra = 14'h10C0;
                    1: ra = 14'h1030;
                    2: ra = 14'h10A0;
                    3: ra = 14'h1050;
                    4: ra = 14'h10F0;
                    default: ra = 14'h1000 | 14'($urandom_range(0, 'hFFF));
                endcase
            end else begin
                ra = 14'($urandom_range(0, 'h3FFF));
            end
            set_bus(ra, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 1) == 1));
            tick();
        end
        set_bus(14'h0000, 1'b1, 1'b1, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
